// File: rtl/count_tracker.sv
// Receive-side tracker for a free-running modular counter: infers direction,
// rebuilds a wide absolute position across wraps and latches a fault on repeated bad steps.
module count_tracker #(
  parameter int CW        = 4,
  parameter int EXT_W     = 16,
  parameter int LOCK_N    = 2,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    count_in,
  input  logic             sample_en,
  input  logic             clear,
  output logic             dir,
  output logic             locked,
  output logic             fault,
  output logic [EXT_W-1:0] position,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             step_err,
  output logic [7:0]       err_cnt,
  output logic [1:0]       state_dbg
);

  localparam int RW = $clog2(LOCK_N + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [RW-1:0] RUN_LOCK = RW'(LOCK_N);
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] prev;
  logic [RW-1:0] run;
  logic [EW-1:0] consec_err;

  logic [CW-1:0] delta;
  logic          is_up;
  logic          is_dn;
  logic          is_err;
  logic          legal;
  logic [RW-1:0] run_nx;
  logic [EW-1:0] consec_nx;
  logic [7:0]    err_inc;

  assign state_dbg = state;

  // Step decode against the previous sample; delta is taken modulo 2^CW.
  always_comb begin
    delta     = count_in - prev;
    is_up     = (delta == CW'(1));
    is_dn     = (delta == {CW{1'b1}});
    is_err    = !is_up && !is_dn && (delta != '0);
    legal     = is_up || is_dn;
    run_nx    = (is_up == dir) ? run + RW'(1) : RW'(1);
    consec_nx = consec_err + EW'(1);
    err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  // sample_en is a valid-only qualifier: there is no ready, every asserted
  // sample is consumed on the edge it is seen; clear outranks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      consec_err <= '0;
      dir        <= 1'b1;
      locked     <= 1'b0;
      fault      <= 1'b0;
      position   <= '0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      step_err <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        prev       <= '0;
        run        <= '0;
        consec_err <= '0;
        dir        <= 1'b1;
        locked     <= 1'b0;
        fault      <= 1'b0;
        position   <= '0;
        err_cnt    <= '0;
      end else if (sample_en) begin
        case (state)
          IDLE: begin
            prev  <= count_in;
            run   <= '0;
            state <= ACQ;
          end
          ACQ: begin
            prev <= count_in;
            if (legal) begin
              wrap_up <= is_up && (prev == {CW{1'b1}});
              wrap_dn <= is_dn && (prev == '0);
              dir     <= is_up;
              run     <= run_nx;
              if (run_nx == RUN_LOCK) begin
                state    <= LOCK;
                locked   <= 1'b1;
                position <= EXT_W'(count_in);
              end
            end else if (is_err) begin
              step_err <= 1'b1;
              err_cnt  <= err_inc;
              run      <= '0;
            end
          end
          LOCK: begin
            prev <= count_in;
            if (legal) begin
              wrap_up    <= is_up && (prev == {CW{1'b1}});
              wrap_dn    <= is_dn && (prev == '0);
              dir        <= is_up;
              consec_err <= '0;
              position   <= is_up ? position + EXT_W'(1) : position - EXT_W'(1);
            end else if (is_err) begin
              step_err   <= 1'b1;
              err_cnt    <= err_inc;
              consec_err <= consec_nx;
              if (consec_nx == ERR_MAX) begin
                state  <= FAULT;
                locked <= 1'b0;
                fault  <= 1'b1;
              end
            end
          end
          default: ; // FAULT holds everything until clear or rst
        endcase
      end
    end
  end

endmodule
